br_resolve_unit: RTL and testbench

//  EX-stage consumer of the IF branch-prediction word (rv32i_brp_word) carried down the pipe.

---
 rtl/br_resolve_unit_pkg.sv | 30 +++
 rtl/br_resolve_unit_if.sv | 38 +++
 rtl/br_resolve_unit_sat_counter.sv | 21 ++
 rtl/br_resolve_unit.sv | 87 ++++++++
 tb/tb_br_resolve_unit.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/br_resolve_unit_pkg.sv
// Shared RV32I types for EX-stage branch resolution: opcodes, the IF prediction word, FSM states.
package br_resolve_unit_pkg;
  localparam int RV_XLEN = 32;

  typedef enum logic [6:0] {
    op_lui   = 7'b0110111,
    op_auipc = 7'b0010111,
    op_jal   = 7'b1101111,
    op_jalr  = 7'b1100111,
    op_br    = 7'b1100011,
    op_load  = 7'b0000011,
    op_store = 7'b0100011,
    op_imm   = 7'b0010011,
    op_reg   = 7'b0110011
  } rv32i_opcode;

  // brp_alt is the path not predicted at IF; it is the correct PC whenever the guess was wrong.
  typedef struct packed {
    logic               predicted;
    logic               prediction;
    logic [RV_XLEN-1:0] brp_target;
    logic [RV_XLEN-1:0] brp_alt;
    logic               mispredicted;
  } rv32i_brp_word;

  typedef logic [1:0] br_res_state_t;
  localparam br_res_state_t IDLE     = 2'd0;
  localparam br_res_state_t REDIRECT = 2'd1;
  localparam br_res_state_t DRAIN    = 2'd2;
endpackage

// File: rtl/br_resolve_unit_if.sv
// EX-side inputs, fetch redirect handshake, PHT training and counter outputs of the resolve unit.
interface br_resolve_unit_if
  import br_resolve_unit_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int CNT_W     = 32,
  parameter int PHT_IDX_W = 8
) ();
  logic                 ex_valid;
  rv32i_opcode          ex_opcode;
  logic [XLEN-1:0]      ex_pc;
  rv32i_brp_word        ex_brp;
  logic                 br_en;
  logic [XLEN-1:0]      jalr_target;
  logic                 redirect_valid;
  logic [XLEN-1:0]      redirect_pc;
  logic                 redirect_ready;
  logic                 flush_if_id;
  logic                 train_valid;
  logic [PHT_IDX_W-1:0] train_idx;
  logic                 train_taken;
  rv32i_brp_word        brp_ex_out;
  logic [CNT_W-1:0]     c_total;
  logic [CNT_W-1:0]     c_correct;
  logic [CNT_W-1:0]     c_redirect;

  modport slave (
    input  ex_valid, ex_opcode, ex_pc, ex_brp, br_en, jalr_target, redirect_ready,
    output redirect_valid, redirect_pc, flush_if_id, train_valid, train_idx, train_taken,
           brp_ex_out, c_total, c_correct, c_redirect
  );

  modport master (
    output ex_valid, ex_opcode, ex_pc, ex_brp, br_en, jalr_target, redirect_ready,
    input  redirect_valid, redirect_pc, flush_if_id, train_valid, train_idx, train_taken,
           brp_ex_out, c_total, c_correct, c_redirect
  );
endinterface

// File: rtl/br_resolve_unit_sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_inc,
  output logic [W-1:0] o_count
);
  logic [W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_inc && (r_count != {W{1'b1}})) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_count = r_count;
endmodule

// File: rtl/br_resolve_unit.sv
// EX branch resolution: checks the IF prediction, issues a registered fetch redirect with a
// one-slot drain, trains the PHT and keeps saturating accuracy counters.
module br_resolve_unit
  import br_resolve_unit_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int CNT_W     = 32,
  parameter int PHT_IDX_W = 8
) (
  input logic               clk,
  input logic               rst,
  br_resolve_unit_if.slave  bus
);
  br_res_state_t        r_state;
  logic [XLEN-1:0]      r_redirect_pc;
  logic                 r_train_valid;
  logic [PHT_IDX_W-1:0] r_train_idx;
  logic                 r_train_taken;

  logic            w_is_br;
  logic            w_is_jalr;
  logic            w_resolve;
  logic            w_br_mis;
  logic            w_redirect_req;
  logic [XLEN-1:0] w_next_pc;
  logic            w_unused_ok;

  assign w_is_br   = (bus.ex_opcode == op_br);
  assign w_is_jalr = (bus.ex_opcode == op_jalr);
  // Only IDLE resolves; anything arriving in REDIRECT/DRAIN is already on the wrong path.
  assign w_resolve = bus.ex_valid && (r_state == IDLE) &&
                     (w_is_br || w_is_jalr || (bus.ex_opcode == op_jal));
  assign w_br_mis       = w_is_br && (bus.br_en != bus.ex_brp.prediction);
  assign w_redirect_req = w_resolve && (w_br_mis || w_is_jalr);
  assign w_next_pc      = w_is_jalr ? {bus.jalr_target[XLEN-1:1], 1'b0} : bus.ex_brp.brp_alt;

  always_comb begin
    bus.brp_ex_out              = bus.ex_brp;
    bus.brp_ex_out.mispredicted = w_redirect_req;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= IDLE;
      r_redirect_pc <= '0;
      r_train_valid <= 1'b0;
      r_train_idx   <= '0;
      r_train_taken <= 1'b0;
    end else begin
      r_train_valid <= w_resolve && w_is_br;
      if (w_resolve && w_is_br) begin
        r_train_idx   <= bus.ex_pc[PHT_IDX_W+1:2];
        r_train_taken <= bus.br_en;
      end
      case (r_state)
        IDLE: begin
          if (w_redirect_req) begin
            r_state       <= REDIRECT;
            r_redirect_pc <= w_next_pc;
          end
        end
        REDIRECT: if (bus.redirect_ready) r_state <= DRAIN;
        DRAIN:    r_state <= IDLE;
        default:  r_state <= IDLE;
      endcase
    end
  end

  assign bus.redirect_valid = (r_state == REDIRECT);
  assign bus.redirect_pc    = r_redirect_pc;
  assign bus.flush_if_id    = bus.redirect_valid && bus.redirect_ready;
  assign bus.train_valid    = r_train_valid;
  assign bus.train_idx      = r_train_idx;
  assign bus.train_taken    = r_train_taken;

  sat_counter #(.W(CNT_W)) u_c_total (
    .clk(clk), .rst(rst), .i_inc(w_resolve && w_is_br), .o_count(bus.c_total)
  );
  sat_counter #(.W(CNT_W)) u_c_correct (
    .clk(clk), .rst(rst), .i_inc(w_resolve && w_is_br && !w_br_mis), .o_count(bus.c_correct)
  );
  sat_counter #(.W(CNT_W)) u_c_redirect (
    .clk(clk), .rst(rst), .i_inc(w_redirect_req), .o_count(bus.c_redirect)
  );

  assign w_unused_ok = &{1'b0, bus.ex_pc[XLEN-1:PHT_IDX_W+2], bus.ex_pc[1:0], bus.jalr_target[0]};
endmodule

// File: tb/tb_br_resolve_unit.sv
// Directed bench for br_resolve_unit with a redirect/train scoreboard and a 4-bit counter instance.
module tb_br_resolve_unit;
  import br_resolve_unit_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;

  logic [31:0] rq[$];
  logic [8:0]  tq[$];

  always #5 clk = ~clk;

  br_resolve_unit_if #(.XLEN(32), .CNT_W(32), .PHT_IDX_W(8)) bus ();
  br_resolve_unit_if #(.XLEN(32), .CNT_W(4),  .PHT_IDX_W(8)) bus2 ();

  br_resolve_unit #(.XLEN(32), .CNT_W(32), .PHT_IDX_W(8)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
  br_resolve_unit #(.XLEN(32), .CNT_W(4), .PHT_IDX_W(8)) dut_sat (
    .clk(clk), .rst(rst), .bus(bus2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (bus.train_valid === 1'b1) begin
      if (tq.size() == 0) begin
        check("unexpected_train", 32'd1, 32'd0);
      end else begin
        logic [8:0] t;
        t = tq.pop_front();
        check("train_idx", {24'd0, bus.train_idx}, {24'd0, t[8:1]});
        check("train_taken", {31'd0, bus.train_taken}, {31'd0, t[0]});
      end
    end
    if (bus.flush_if_id === 1'b1) begin
      if (rq.size() == 0) begin
        check("unexpected_redirect", 32'd1, 32'd0);
      end else begin
        logic [31:0] p;
        p = rq.pop_front();
        check("redirect_pc", bus.redirect_pc, p);
      end
    end
  end

  task automatic drive_br(input logic [31:0] pc, input logic pred, input logic taken,
                          input logic [31:0] tgt, input logic [31:0] alt, input logic live);
    bus.ex_valid  = 1'b1;
    bus.ex_opcode = op_br;
    bus.ex_pc     = pc;
    bus.ex_brp    = '{predicted: 1'b1, prediction: pred, brp_target: tgt, brp_alt: alt,
                      mispredicted: 1'b0};
    bus.br_en     = taken;
    if (live) begin
      tq.push_back({pc[9:2], taken});
      if (taken != pred) rq.push_back(alt);
    end
    #1;
    check("brp_mispredicted", {31'd0, bus.brp_ex_out.mispredicted},
          {31'd0, live && (taken != pred)});
    check("brp_alt_pass", bus.brp_ex_out.brp_alt, alt);
    step();
    bus.ex_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    bus.ex_valid = 1'b0; bus.ex_opcode = op_imm; bus.ex_pc = '0; bus.ex_brp = '0;
    bus.br_en = 1'b0; bus.jalr_target = '0; bus.redirect_ready = 1'b1;
    bus2.ex_valid = 1'b0; bus2.ex_opcode = op_imm; bus2.ex_pc = '0; bus2.ex_brp = '0;
    bus2.br_en = 1'b0; bus2.jalr_target = '0; bus2.redirect_ready = 1'b1;

    do_reset();
    check("rst_redirect_valid", {31'd0, bus.redirect_valid}, 32'd0);
    check("rst_redirect_pc", bus.redirect_pc, 32'd0);
    check("rst_train_valid", {31'd0, bus.train_valid}, 32'd0);
    check("rst_c_total", bus.c_total, 32'd0);
    check("rst_c_redirect", bus.c_redirect, 32'd0);

    // 1: not-taken mispredict
    drive_br(32'h100, 1'b1, 1'b0, 32'h140, 32'h104, 1'b1);
    check("t1_redirect_valid", {31'd0, bus.redirect_valid}, 32'd1);
    check("t1_redirect_pc", bus.redirect_pc, 32'h104);
    check("t1_c_total", bus.c_total, 32'd1);
    check("t1_c_correct", bus.c_correct, 32'd0);
    step();
    step();

    // 2: correct not-taken prediction
    do_reset();
    drive_br(32'h104, 1'b0, 1'b0, 32'h108, 32'h180, 1'b1);
    check("t2_redirect_valid", {31'd0, bus.redirect_valid}, 32'd0);
    check("t2_c_total", bus.c_total, 32'd1);
    check("t2_c_correct", bus.c_correct, 32'd1);
    step();

    // 3: JALR with fetch stalling the redirect for 3 cycles
    do_reset();
    bus.redirect_ready = 1'b0;
    bus.ex_valid = 1'b1; bus.ex_opcode = op_jalr; bus.ex_pc = 32'h200;
    bus.ex_brp = '0; bus.jalr_target = 32'h2003;
    rq.push_back(32'h2002);
    #1;
    check("t3_brp_mispredicted", {31'd0, bus.brp_ex_out.mispredicted}, 32'd1);
    step();
    bus.ex_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("t3_hold_valid", {31'd0, bus.redirect_valid}, 32'd1);
      check("t3_hold_pc", bus.redirect_pc, 32'h2002);
      check("t3_no_flush", {31'd0, bus.flush_if_id}, 32'd0);
      if (i < 2) step();
    end
    bus.redirect_ready = 1'b1;
    #1;
    check("t3_flush", {31'd0, bus.flush_if_id}, 32'd1);
    step();
    check("t3_flush_end", {31'd0, bus.flush_if_id}, 32'd0);
    check("t3_c_redirect", bus.c_redirect, 32'd1);
    check("t3_c_total", bus.c_total, 32'd0);
    step();

    // 4: wrong-path ops in REDIRECT and DRAIN, then ex_valid=0 with a branch opcode
    do_reset();
    drive_br(32'h300, 1'b1, 1'b0, 32'h340, 32'h304, 1'b1);
    drive_br(32'h304, 1'b1, 1'b0, 32'h380, 32'h308, 1'b0);
    drive_br(32'h308, 1'b0, 1'b1, 32'h30c, 32'h3c0, 1'b0);
    bus.ex_opcode = op_br; bus.ex_brp.prediction = 1'b0; bus.br_en = 1'b1;
    #1;
    check("t4_invalid_mis", {31'd0, bus.brp_ex_out.mispredicted}, 32'd0);
    step();
    check("t4_redirect_valid", {31'd0, bus.redirect_valid}, 32'd0);
    check("t4_c_total", bus.c_total, 32'd1);
    check("t4_c_redirect", bus.c_redirect, 32'd1);
    step();

    // 5: reset while the redirect is pending
    do_reset();
    bus.redirect_ready = 1'b0;
    drive_br(32'h400, 1'b0, 1'b1, 32'h404, 32'h480, 1'b1);
    check("t5_redirect_valid", {31'd0, bus.redirect_valid}, 32'd1);
    rst = 1'b1;
    step();
    rq.delete();
    check("t5_rst_redirect_valid", {31'd0, bus.redirect_valid}, 32'd0);
    check("t5_rst_c_total", bus.c_total, 32'd0);
    check("t5_rst_c_redirect", bus.c_redirect, 32'd0);
    rst = 1'b0;
    bus.redirect_ready = 1'b1;
    drive_br(32'h410, 1'b1, 1'b1, 32'h420, 32'h414, 1'b1);
    check("t5_c_total", bus.c_total, 32'd1);
    check("t5_c_correct", bus.c_correct, 32'd1);
    step();

    // 6: 4-bit counters saturate
    for (int i = 0; i < 20; i++) begin
      bus2.ex_valid = 1'b1; bus2.ex_opcode = op_br; bus2.ex_pc = 32'h500 + 32'(i * 4);
      bus2.ex_brp = '{predicted: 1'b1, prediction: 1'b1, brp_target: 32'h600,
                      brp_alt: 32'h504, mispredicted: 1'b0};
      bus2.br_en = 1'b1;
      step();
      if (i == 13) check("t6_c_total_14", {28'd0, bus2.c_total}, 32'd14);
    end
    bus2.ex_valid = 1'b0;
    step();
    check("t6_c_total", {28'd0, bus2.c_total}, 32'd15);
    check("t6_c_correct", {28'd0, bus2.c_correct}, 32'd15);
    check("t6_c_redirect", {28'd0, bus2.c_redirect}, 32'd0);

    step();
    check("redirects_outstanding", rq.size(), 32'd0);
    check("trains_outstanding", tq.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
